// File: rtl/spi_sram_pkg.sv
// Shared definitions for spi_sram_ctrl: SPI commands, frame sizing, FSM states.
// SPI_FAST_READ_EN widens the frame to 48 bits for FAST READ (0x0B + 8 dummy bits).
package spi_sram_pkg;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_WRITE     = 8'h02;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;

    localparam int FRAME_LEN_STD  = 40;
    localparam int FRAME_LEN_FAST = 48;

`ifdef SPI_FAST_READ_EN
    localparam int FRAME_W = FRAME_LEN_FAST;
`else
    localparam int FRAME_W = FRAME_LEN_STD;
`endif
    localparam int BIT_CNT_W = $clog2(FRAME_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        ACK,
        RECOVER
    } state_t;

    typedef struct packed {
        logic        we;
        logic [23:0] adr;
        logic [7:0]  dat;
    } spi_req_t;

    // Frame is left-aligned in the shift register; MOSI is always its MSB.
    function automatic logic [FRAME_W-1:0] build_frame(input spi_req_t req);
`ifdef SPI_FAST_READ_EN
        if (req.we) return {CMD_WRITE, req.adr, req.dat, 8'h00};
        return {CMD_FAST_READ, req.adr, 16'h0000};
`else
        return {req.we ? CMD_WRITE : CMD_READ, req.adr, req.we ? req.dat : 8'h00};
`endif
    endfunction

endpackage

// File: rtl/spi_sram_phy.sv
// SPI mode-0 shifter for spi_sram_ctrl: SCK divider, TX/RX shift registers, bit counter.
// Frame width follows SPI_FAST_READ_EN through spi_sram_pkg::FRAME_W.
module spi_sram_phy
    import spi_sram_pkg::*;
#(
    parameter int SCK_HALF_PERIOD = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start,
    input  logic [FRAME_W-1:0]   frame,
    input  logic [BIT_CNT_W-1:0] frame_len,
    input  logic                 shift_en,
    input  logic                 abort,
    input  logic                 miso,
    output logic                 sck,
    output logic                 mosi,
    output logic                 done,
    output logic [7:0]           rx_byte
);

    localparam int HC_W = (SCK_HALF_PERIOD > 1) ? $clog2(SCK_HALF_PERIOD) : 1;
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(SCK_HALF_PERIOD - 1);

    logic [FRAME_W-1:0]   tx_sr;
    logic [7:0]           rx_sr;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [BIT_CNT_W-1:0] len_q;
    logic [HC_W-1:0]      hcnt;
    logic                 sck_q;
    logic                 tick;

    assign tick    = shift_en && (hcnt == HC_LAST);
    // Asserted on the edge that produces the final falling SCK edge.
    assign done    = tick && sck_q && (bit_cnt == len_q - BIT_CNT_W'(1));
    assign sck     = sck_q;
    assign mosi    = tx_sr[FRAME_W-1];
    assign rx_byte = rx_sr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_sr   <= '0;
            rx_sr   <= '0;
            bit_cnt <= '0;
            len_q   <= '0;
            hcnt    <= '0;
            sck_q   <= 1'b0;
        end else if (abort) begin
            tx_sr   <= '0;
            bit_cnt <= '0;
            hcnt    <= '0;
            sck_q   <= 1'b0;
        end else if (start) begin
            tx_sr   <= frame;
            len_q   <= frame_len;
            bit_cnt <= '0;
            hcnt    <= '0;
            sck_q   <= 1'b0;
        end else if (shift_en) begin
            if (tick) begin
                hcnt  <= '0;
                sck_q <= !sck_q;
                if (!sck_q) begin
                    rx_sr <= {rx_sr[6:0], miso};
                end else begin
                    // Zero fill leaves MOSI low once the frame has drained.
                    tx_sr   <= {tx_sr[FRAME_W-2:0], 1'b0};
                    bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                end
            end else begin
                hcnt <= hcnt + HC_W'(1);
            end
        end
    end

endmodule

// File: rtl/spi_sram_ctrl.sv
// Wishbone B4 pipelined slave doing one byte read/write per cycle to a serial SRAM over SPI mode 0.
// Defining SPI_FAST_READ_EN switches reads to FAST READ (0x0B) with 8 dummy bits.
module spi_sram_ctrl
    import spi_sram_pkg::*;
#(
    parameter int ADR_WIDTH       = 23,
    parameter int SCK_HALF_PERIOD = 1,
    parameter int CS_HIGH_CYCLES  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cyc_i,
    input  logic                 stb_i,
    input  logic                 we_i,
    input  logic [ADR_WIDTH-1:0] adr_i,
    input  logic [7:0]           dat_i,
    output logic [7:0]           dat_o,
    output logic                 ack_o,
    output logic                 err_o,
    output logic                 rty_o,
    output logic                 stall_o,
    output logic                 spi_sck,
    output logic                 spi_cs_n,
    output logic                 spi_mosi,
    input  logic                 spi_miso
);

    localparam int REC_W = (CS_HIGH_CYCLES > 2) ? $clog2(CS_HIGH_CYCLES - 1) : 1;
    localparam logic [REC_W-1:0] REC_LAST = REC_W'((CS_HIGH_CYCLES > 1) ? CS_HIGH_CYCLES - 2 : 0);
    localparam state_t POST_CS = state_t'((CS_HIGH_CYCLES > 1) ? RECOVER : IDLE);

    state_t               state, state_nxt;
    spi_req_t             req;
    logic                 accept, abort, phy_shift, phy_done;
    logic                 we_q, ack_q, cs_n_q;
    logic [REC_W-1:0]     rec_cnt;
    logic [7:0]           dat_q, rx_byte;
    logic [BIT_CNT_W-1:0] len;

    assign accept    = (state == IDLE) && cyc_i && stb_i;
    assign abort     = (state == SETUP || state == SHIFT || state == HOLD) && !cyc_i;
    assign phy_shift = (state == SHIFT) && cyc_i;
    assign req       = '{we: we_i, adr: 24'(adr_i), dat: dat_i};

`ifdef SPI_FAST_READ_EN
    assign len = we_i ? BIT_CNT_W'(FRAME_LEN_STD) : BIT_CNT_W'(FRAME_LEN_FAST);
`else
    assign len = BIT_CNT_W'(FRAME_LEN_STD);
`endif

    spi_sram_phy #(
        .SCK_HALF_PERIOD(SCK_HALF_PERIOD)
    ) u_phy (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start    (accept),
        .frame    (build_frame(req)),
        .frame_len(len),
        .shift_en (phy_shift),
        .abort    (abort),
        .miso     (spi_miso),
        .sck      (spi_sck),
        .mosi     (spi_mosi),
        .done     (phy_done),
        .rx_byte  (rx_byte)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SETUP;
            SETUP:   state_nxt = abort ? POST_CS : SHIFT;
            SHIFT:   if (abort) state_nxt = POST_CS;
                     else if (phy_done) state_nxt = HOLD;
            HOLD:    state_nxt = abort ? POST_CS : ACK;
            ACK:     state_nxt = POST_CS;
            RECOVER: if (rec_cnt == REC_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            rec_cnt <= '0;
            we_q    <= 1'b0;
            ack_q   <= 1'b0;
            cs_n_q  <= 1'b1;
            dat_q   <= 8'h00;
        end else begin
            state   <= state_nxt;
            rec_cnt <= (state == RECOVER) ? rec_cnt + REC_W'(1) : '0;
            // Outputs registered from next state so CS/ACK never glitch on state decode.
            ack_q   <= (state_nxt == ACK);
            cs_n_q  <= !(state_nxt == SETUP || state_nxt == SHIFT || state_nxt == HOLD);
            if (accept) we_q <= we_i;
            if (state == HOLD && state_nxt == ACK && !we_q) dat_q <= rx_byte;
        end
    end

    assign stall_o  = (state != IDLE);
    assign ack_o    = ack_q;
    assign dat_o    = dat_q;
    assign spi_cs_n = cs_n_q;
    assign err_o    = 1'b0;
    assign rty_o    = 1'b0;

endmodule

// File: tb/tb_spi_sram_ctrl.sv
// Directed bench for spi_sram_ctrl: vector table plus abort, back-to-back and async-reset sequences.
// Build with SPI_FAST_READ_EN to exercise FAST READ at SCK_HALF_PERIOD=3.
`timescale 1ns/1ps
module tb_spi_sram_ctrl;

`ifdef SPI_FAST_READ_EN
    localparam int H    = 3;
    localparam bit FAST = 1'b1;
`else
    localparam int H    = 1;
    localparam bit FAST = 1'b0;
`endif
    localparam int CS_HI = 2;

    logic        clk_i = 1'b0, rst_i = 1'b1;
    logic        cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
    logic [22:0] adr_i = '0;
    logic [7:0]  dat_i = '0;
    logic [7:0]  dat_o;
    logic        ack_o, err_o, rty_o, stall_o;
    logic        spi_sck, spi_cs_n, spi_mosi, spi_miso;

    spi_sram_ctrl #(
        .ADR_WIDTH      (23),
        .SCK_HALF_PERIOD(H),
        .CS_HIGH_CYCLES (CS_HI)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .cyc_i   (cyc_i),
        .stb_i   (stb_i),
        .we_i    (we_i),
        .adr_i   (adr_i),
        .dat_i   (dat_i),
        .dat_o   (dat_o),
        .ack_o   (ack_o),
        .err_o   (err_o),
        .rty_o   (rty_o),
        .stall_o (stall_o),
        .spi_sck (spi_sck),
        .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso)
    );

    always #5 clk_i = ~clk_i;

    // SPI SRAM model: returns miso_byte in the last 8 bit slots, ones elsewhere.
    logic [7:0]  miso_byte = 8'h00;
    logic [47:0] mosi_cap  = '0;
    int          fall_cnt  = 0;
    int          rise_cnt  = 0;
    int          tb_len    = 40;

    always @(negedge spi_sck or posedge spi_cs_n)
        if (spi_cs_n) fall_cnt = 0;
        else          fall_cnt = fall_cnt + 1;

    always @(posedge spi_sck or negedge spi_cs_n)
        if (!spi_sck) begin
            rise_cnt = 0;
            mosi_cap = '0;
        end else if (!spi_cs_n) begin
            mosi_cap = {mosi_cap[46:0], spi_mosi};
            rise_cnt = rise_cnt + 1;
        end

    always_comb begin
        spi_miso = 1'b1;
        if (fall_cnt >= tb_len - 8 && fall_cnt < tb_len)
            spi_miso = miso_byte[3'(tb_len - 1 - fall_cnt)];
    end

    typedef struct {
        logic        we;
        logic [22:0] adr;
        logic [7:0]  dat;
        logic [7:0]  miso;
        logic [39:0] frame;
        logic [7:0]  exp_dat;
    } vec_t;

    vec_t vecs[6];
    int   total  = 0;
    int   passed = 0;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    function automatic int exp_lat(input logic we);
        return 2 + (((FAST && !we) ? 96 : 80) * H);
    endfunction

    function automatic logic [47:0] exp_frame(input vec_t v);
        if (FAST && !v.we) return {8'h0B, v.frame[31:8], 16'h0000};
        return {8'h00, v.frame};
    endfunction

    // Called at a negedge; returns #1 after the accepting edge with stb dropped.
    task automatic start_req(input string tag, input logic we, input logic [22:0] adr,
                             input logic [7:0] dat);
        check({tag, "_stall_idle"}, 48'(stall_o), 48'(0));
        cyc_i  = 1'b1;
        stb_i  = 1'b1;
        we_i   = we;
        adr_i  = adr;
        dat_i  = dat;
        tb_len = (FAST && !we) ? 48 : 40;
        @(posedge clk_i);
        #1 stb_i = 1'b0;
    endtask

    task automatic wait_ack(output int lat, output int cs_low, output int stall_low);
        lat = 0; cs_low = 0; stall_low = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk_i);
            if (ack_o) return;
            if (!spi_cs_n) cs_low++;
            if (!stall_o) stall_low++;
            lat++;
        end
        lat = -1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat, csl, stl;
        miso_byte = v.miso;
        start_req(tag, v.we, v.adr, v.dat);
        wait_ack(lat, csl, stl);
        check({tag, "_latency"}, 48'(lat), 48'(exp_lat(v.we)));
        check({tag, "_cs_low"}, 48'(csl), 48'(exp_lat(v.we)));
        check({tag, "_stall_busy"}, 48'(stl), 48'(0));
        check({tag, "_dat_o"}, 48'(dat_o), 48'(v.exp_dat));
        check({tag, "_mosi"}, mosi_cap, exp_frame(v));
        check({tag, "_bits"}, 48'(rise_cnt), 48'(tb_len));
        @(negedge clk_i);
        check({tag, "_ack_pulse"}, 48'(ack_o), 48'(0));
        cyc_i = 1'b0;
        repeat (CS_HI) @(negedge clk_i);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   lat, csl, stl, acks, gap, ok, n;
        vec_t v;

        vecs[0] = '{we: 1'b1, adr: 23'h012345, dat: 8'h5A, miso: 8'h00, frame: 40'h02_012345_5A, exp_dat: 8'h00};
        vecs[1] = '{we: 1'b0, adr: 23'h7FFFFF, dat: 8'h77, miso: 8'hA5, frame: 40'h03_7FFFFF_00, exp_dat: 8'hA5};
        vecs[2] = '{we: 1'b1, adr: 23'h000000, dat: 8'h3C, miso: 8'h00, frame: 40'h02_000000_3C, exp_dat: 8'hA5};
        vecs[3] = '{we: 1'b0, adr: 23'h000001, dat: 8'hFF, miso: 8'h81, frame: 40'h03_000001_00, exp_dat: 8'h81};
        vecs[4] = '{we: 1'b0, adr: 23'h400000, dat: 8'h00, miso: 8'hFF, frame: 40'h03_400000_00, exp_dat: 8'hFF};
        vecs[5] = '{we: 1'b1, adr: 23'h2AAAAA, dat: 8'hC3, miso: 8'h00, frame: 40'h02_2AAAAA_C3, exp_dat: 8'hFF};

        repeat (3) @(negedge clk_i);
        check("rst_cs_n", 48'(spi_cs_n), 48'(1));
        check("rst_sck", 48'(spi_sck), 48'(0));
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_mosi", 48'(spi_mosi), 48'(0));
        check("rst_ack", 48'(ack_o), 48'(0));
        check("rst_stall", 48'(stall_o), 48'(0));
        check("rst_dat_o", 48'(dat_o), 48'(0));
        check("err_rty", 48'({err_o, rty_o}), 48'(0));

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Back-to-back: B held on the bus while A is in flight.
        start_req("b2b_a", 1'b1, 23'h000010, 8'h11);
        stb_i = 1'b1; we_i = 1'b0; adr_i = 23'h000020;
        miso_byte = 8'h6E;
        tb_len = FAST ? 48 : 40;
        acks = 0; gap = 0; ok = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk_i);
            if (ack_o) acks++;
            if (acks > 0 && spi_cs_n) gap++;
            if (!stall_o) begin ok = 1; break; end
        end
        check("b2b_reach_idle", 48'(ok), 48'(1));
        check("b2b_first_ack", 48'(acks), 48'(1));
        check("b2b_cs_gap", 48'(gap >= CS_HI), 48'(1));
        @(posedge clk_i);
        #1 stb_i = 1'b0;
        wait_ack(lat, csl, stl);
        v = '{we: 1'b0, adr: 23'h000020, dat: 8'h00, miso: 8'h6E, frame: 40'h03_000020_00, exp_dat: 8'h6E};
        check("b2b_latency", 48'(lat), 48'(exp_lat(1'b0)));
        check("b2b_dat_o", 48'(dat_o), 48'(8'h6E));
        check("b2b_mosi", mosi_cap, exp_frame(v));
        @(negedge clk_i);
        cyc_i = 1'b0;
        repeat (CS_HI) @(negedge clk_i);

        // Abort at the 20th falling SCK edge.
        start_req("abort", 1'b1, 23'h055555, 8'h99);
        ok = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk_i);
            if (fall_cnt == 20) begin ok = 1; break; end
        end
        check("abort_reach20", 48'(ok), 48'(1));
        cyc_i = 1'b0;
        @(negedge clk_i);
        check("abort_cs_n", 48'(spi_cs_n), 48'(1));
        check("abort_sck", 48'(spi_sck), 48'(0));
        check("abort_mosi", 48'(spi_mosi), 48'(0));
        n = 0; acks = 0;
        for (int k = 0; k < 50; k++) begin
            if (ack_o) acks++;
            if (!stall_o) break;
            n++;
            @(negedge clk_i);
        end
        check("abort_no_ack", 48'(acks), 48'(0));
        check("abort_recover", 48'(n), 48'(CS_HI - 1));
        run_vec('{we: 1'b0, adr: 23'h000003, dat: 8'h00, miso: 8'h5C, frame: 40'h03_000003_00, exp_dat: 8'h5C},
                "post_abort");

        // Asynchronous reset between edges while SCK is high mid-frame.
        miso_byte = 8'hE7;
        start_req("arst", 1'b0, 23'h001234, 8'h00);
        ok = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk_i);
            if (fall_cnt >= 10 && spi_sck) begin ok = 1; break; end
        end
        check("arst_reach", 48'(ok), 48'(1));
        #2 rst_i = 1'b1;
        #1;
        check("arst_cs_n", 48'(spi_cs_n), 48'(1));
        check("arst_sck", 48'(spi_sck), 48'(0));
        check("arst_mosi", 48'(spi_mosi), 48'(0));
        check("arst_ack", 48'(ack_o), 48'(0));
        @(negedge clk_i);
        rst_i = 1'b0;
        cyc_i = 1'b0;
        @(negedge clk_i);
        check("arst_stall", 48'(stall_o), 48'(0));
        check("arst_ack_after", 48'(ack_o), 48'(0));
        check("arst_dat_o", 48'(dat_o), 48'(0));
        run_vec('{we: 1'b0, adr: 23'h0ABCDE, dat: 8'h00, miso: 8'h96, frame: 40'h03_0ABCDE_00, exp_dat: 8'h96},
                "post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
